brg_hcc_freeze_ctrl: RTL and testbench

BRG_HCC_FREEZE_CTRL -- requirements
Module: brg_hcc_freeze_ctrl

---
 rtl/brg_hcc_freeze_pkg.sv | 34 +++
 rtl/brg_hcc_freeze_ctrl_if.sv | 36 +++
 rtl/brg_hcc_freeze_fsm.sv | 85 ++++++++
 rtl/brg_hcc_freeze_ctrl.sv | 134 +++++++++++++
 tb/tb_brg_hcc_freeze_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/brg_hcc_freeze_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : brg_hcc_freeze_pkg
//  Purpose : Shared types and constants for the HCC freeze controller:
//            the per-core freeze FSM state encoding and the bit positions of
//            the per-core status word returned on CSR loads.
//  Ports   : none (package)
//  Config  : BRG_HCC_FREEZE_DRAIN_EN (used by importers, not here)
//  Rev     : 1.0  initial release
// ============================================================================
package brg_hcc_freeze_pkg;

  typedef enum logic [1:0] {
    FRZ_RUN    = 2'd0,
    FRZ_DRAIN  = 2'd1,
    FRZ_FROZEN = 2'd2
  } freeze_state_e;

  // Per-core status word layout: {draining, frozen}
  localparam int unsigned STAT_FROZEN_BIT = 0;
  localparam int unsigned STAT_DRAIN_BIT  = 1;
  localparam int unsigned STAT_WIDTH      = 2;

  function automatic logic [STAT_WIDTH-1:0] pack_status(input logic frozen,
                                                        input logic draining);
    logic [STAT_WIDTH-1:0] s;
    s                  = '0;
    s[STAT_FROZEN_BIT] = frozen;
    s[STAT_DRAIN_BIT]  = draining;
    return s;
  endfunction

endpackage : brg_hcc_freeze_pkg
`default_nettype wire

// File: rtl/brg_hcc_freeze_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : brg_hcc_freeze_ctrl_if
//  Purpose : Slave request/response bus of the freeze controller.
//  Signals : in_v_i / in_we_i      request valid / request is a store
//            in_addr_i / in_data_i request word address / store data
//            in_yumi_o             request consumed
//            returning_v_o/_data_o response valid / load data
//  Modports: master (requester side), slave (controller side)
//  Rev     : 1.0  initial release
// ============================================================================
interface brg_hcc_freeze_ctrl_if #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32
);

  logic                    in_v_i;
  logic                    in_we_i;
  logic [addr_width_p-1:0] in_addr_i;
  logic [data_width_p-1:0] in_data_i;
  logic                    in_yumi_o;
  logic                    returning_v_o;
  logic [data_width_p-1:0] returning_data_o;

  modport master (
    output in_v_i, in_we_i, in_addr_i, in_data_i,
    input  in_yumi_o, returning_v_o, returning_data_o
  );

  modport slave (
    input  in_v_i, in_we_i, in_addr_i, in_data_i,
    output in_yumi_o, returning_v_o, returning_data_o
  );

endinterface : brg_hcc_freeze_ctrl_if
`default_nettype wire

// File: rtl/brg_hcc_freeze_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : brg_hcc_freeze_fsm
//  Purpose : Freeze state machine for one core (RUN / DRAIN / FROZEN).
//            A freeze request stops the core's network traffic; with draining
//            enabled the core is only reported frozen once all outgoing
//            credits have returned.
//  Ports   : clk_i, reset_n_i       clock, async active-low reset
//            freeze_req_i           one-cycle freeze request
//            unfreeze_req_i         one-cycle unfreeze request
//            credits_i              current outgoing credit count
//            frozen_o / draining_o  status flags
//            run_o                  core traffic may pass
//  Config  : BRG_HCC_FREEZE_DRAIN_EN -- when undefined, a freeze request
//            goes straight to FROZEN and draining_o is tied low.
//  Rev     : 1.0  initial release
// ============================================================================
module brg_hcc_freeze_fsm
  import brg_hcc_freeze_pkg::*;
#(
  parameter int credit_width_p    = 8,
  parameter int max_out_credits_p = 200
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      freeze_req_i,
  input  logic                      unfreeze_req_i,
  input  logic [credit_width_p-1:0] credits_i,
  output logic                      frozen_o,
  output logic                      draining_o,
  output logic                      run_o
);

  localparam logic [credit_width_p-1:0] FULL_CREDITS = credit_width_p'(max_out_credits_p);

  freeze_state_e state_r;
  freeze_state_e state_n;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= FRZ_FROZEN;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n    = state_r;
    frozen_o   = (state_r == FRZ_FROZEN);
    run_o      = (state_r == FRZ_RUN);
`ifdef BRG_HCC_FREEZE_DRAIN_EN
    draining_o = (state_r == FRZ_DRAIN);
`else
    draining_o = 1'b0;
`endif

    case (state_r)
      FRZ_RUN: begin
        if (freeze_req_i) begin
`ifdef BRG_HCC_FREEZE_DRAIN_EN
          state_n = FRZ_DRAIN;
`else
          state_n = FRZ_FROZEN;
`endif
        end
      end
      FRZ_DRAIN: begin
        // A cancel wins over credits completing in the same cycle.
        if (unfreeze_req_i) begin
          state_n = FRZ_RUN;
        end else if (credits_i == FULL_CREDITS) begin
          state_n = FRZ_FROZEN;
        end
      end
      FRZ_FROZEN: begin
        if (unfreeze_req_i) begin
          state_n = FRZ_RUN;
        end
      end
      default: state_n = FRZ_FROZEN;
    endcase
  end

endmodule : brg_hcc_freeze_fsm
`default_nettype wire

// File: rtl/brg_hcc_freeze_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : brg_hcc_freeze_ctrl
//  Purpose : CSR-controlled per-core freeze controller. One freeze CSR per
//            core at csr_base_addr_p + k, plus a broadcast CSR right after
//            the last core. Every request is accepted immediately and gets
//            a registered response one cycle later.
//  Ports   : clk_i, reset_n_i    clock, async active-low reset
//            bus (slave)         CSR request / response bus
//            core_v_i/_ready_i   per-core outgoing valid / endpoint ready
//            core_v_o/_ready_o   same, gated off while not running
//            out_credits_i       per-core outgoing credit counts
//            freeze_o            per-core frozen flag
//  Config  : BRG_HCC_FREEZE_DRAIN_EN enables the credit-drain state.
//  Rev     : 1.0  initial release
// ============================================================================
module brg_hcc_freeze_ctrl
  import brg_hcc_freeze_pkg::*;
#(
  parameter int num_cores_p       = 4,
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = 32,
  parameter int max_out_credits_p = 200,
  parameter int csr_base_addr_p   = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  brg_hcc_freeze_ctrl_if.slave    bus,
  input  logic [num_cores_p-1:0]  core_v_i,
  input  logic [num_cores_p-1:0]  core_ready_i,
  output logic [num_cores_p-1:0]  core_v_o,
  output logic [num_cores_p-1:0]  core_ready_o,
  input  logic [num_cores_p-1:0][$clog2(max_out_credits_p+1)-1:0] out_credits_i,
  output logic [num_cores_p-1:0]  freeze_o
);

  localparam int CREDIT_WIDTH = $clog2(max_out_credits_p + 1);

  logic [addr_width_p-1:0] offset;
  logic [num_cores_p-1:0]  hit_core;
  logic                    hit_bcast;
  logic                    store_v;
  logic                    load_v;
  logic [num_cores_p-1:0]  freeze_req;
  logic [num_cores_p-1:0]  unfreeze_req;
  logic [data_width_p-1:0] load_data;

  logic [num_cores_p-1:0]  frozen;
  logic [num_cores_p-1:0]  draining;
  logic [num_cores_p-1:0]  running;

  logic                    resp_v_r;
  logic [data_width_p-1:0] resp_data_r;

  // Only bit 0 of store data carries meaning.
  logic unused_data_bits;
  assign unused_data_bits = ^bus.in_data_i[data_width_p-1:1];

  assign bus.in_yumi_o = bus.in_v_i;
  assign store_v       = bus.in_v_i & bus.in_we_i;
  assign load_v        = bus.in_v_i & ~bus.in_we_i;

  // Offset decode; an offset outside 0..num_cores_p hits nothing.
  always_comb begin
    offset    = bus.in_addr_i - addr_width_p'(csr_base_addr_p);
    hit_bcast = (offset == addr_width_p'(num_cores_p));
    hit_core  = '0;
    for (int i = 0; i < num_cores_p; i++) begin
      hit_core[i] = (offset == addr_width_p'(i));
    end
  end

  always_comb begin
    freeze_req   = '0;
    unfreeze_req = '0;
    for (int i = 0; i < num_cores_p; i++) begin
      if (store_v && (hit_core[i] || hit_bcast)) begin
        freeze_req[i]   =  bus.in_data_i[0];
        unfreeze_req[i] = ~bus.in_data_i[0];
      end
    end
  end

  // Load data reflects the current (pre-update) state.
  always_comb begin
    load_data = '0;
    if (hit_bcast) begin
      load_data = data_width_p'(frozen);
    end else begin
      for (int i = 0; i < num_cores_p; i++) begin
        if (hit_core[i]) begin
          load_data = data_width_p'(pack_status(frozen[i], draining[i]));
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_v_r    <= 1'b0;
      resp_data_r <= '0;
    end else begin
      resp_v_r    <= bus.in_v_i;
      resp_data_r <= load_v ? load_data : '0;
    end
  end

  assign bus.returning_v_o    = resp_v_r;
  assign bus.returning_data_o = resp_data_r;

  generate
    for (genvar k = 0; k < num_cores_p; k++) begin : g_core
      brg_hcc_freeze_fsm #(
        .credit_width_p    (CREDIT_WIDTH),
        .max_out_credits_p (max_out_credits_p)
      ) u_fsm (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .freeze_req_i   (freeze_req[k]),
        .unfreeze_req_i (unfreeze_req[k]),
        .credits_i      (out_credits_i[k]),
        .frozen_o       (frozen[k]),
        .draining_o     (draining[k]),
        .run_o          (running[k])
      );
    end
  endgenerate

  assign freeze_o     = frozen;
  assign core_v_o     = core_v_i & running;
  assign core_ready_o = core_ready_i & running;

endmodule : brg_hcc_freeze_ctrl
`default_nettype wire

// File: tb/tb_brg_hcc_freeze_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_brg_hcc_freeze_ctrl
//  Purpose : Directed self-checking bench for brg_hcc_freeze_ctrl with the
//            default parameters (4 cores, base 0, 200 credits). Expected
//            values follow BRG_HCC_FREEZE_DRAIN_EN when it is defined.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_brg_hcc_freeze_ctrl;

  logic            clk_i;
  logic            reset_n_i;
  logic [3:0]      core_v_i;
  logic [3:0]      core_ready_i;
  logic [3:0]      core_v_o;
  logic [3:0]      core_ready_o;
  logic [3:0][7:0] out_credits_i;
  logic [3:0]      freeze_o;

  int checks   = 0;
  int failures = 0;

  brg_hcc_freeze_ctrl_if #(.data_width_p(32), .addr_width_p(32)) bus ();

  brg_hcc_freeze_ctrl dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .bus           (bus),
    .core_v_i      (core_v_i),
    .core_ready_i  (core_ready_i),
    .core_v_o      (core_v_o),
    .core_ready_o  (core_ready_o),
    .out_credits_i (out_credits_i),
    .freeze_o      (freeze_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One request cycle; returns one cycle after the accepting edge.
  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] data);
    bus.in_v_i    = 1'b1;
    bus.in_we_i   = we;
    bus.in_addr_i = addr;
    bus.in_data_i = data;
    #1;
    check("yumi", {31'd0, bus.in_yumi_o}, 32'd1);
    tick();
    bus.in_v_i    = 1'b0;
    bus.in_we_i   = 1'b0;
    bus.in_addr_i = '0;
    bus.in_data_i = '0;
  endtask

  task automatic load_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    req(1'b0, addr, 32'd0);
    check({tag, "_v"}, {31'd0, bus.returning_v_o}, 32'd1);
    check(tag, bus.returning_data_o, exp);
  endtask

  initial begin
    reset_n_i     = 1'b0;
    bus.in_v_i    = 1'b0;
    bus.in_we_i   = 1'b0;
    bus.in_addr_i = '0;
    bus.in_data_i = '0;
    core_v_i      = 4'b1111;
    core_ready_i  = 4'b0110;
    for (int i = 0; i < 4; i++) out_credits_i[i] = 8'd200;

    // Reset state
    tick(); tick(); tick();
    check("rst_freeze",  {28'd0, freeze_o}, 32'hF);
    check("rst_core_v",  {28'd0, core_v_o}, 32'h0);
    check("rst_core_rdy",{28'd0, core_ready_o}, 32'h0);
    check("rst_ret_v",   {31'd0, bus.returning_v_o}, 32'd0);
    check("rst_ret_data", bus.returning_data_o, 32'd0);
    reset_n_i = 1'b1;
    tick();
    check("post_rst_freeze", {28'd0, freeze_o}, 32'hF);
    check("post_rst_ret_v",  {31'd0, bus.returning_v_o}, 32'd0);

    // Unfreeze core 2
    req(1'b1, 32'd2, 32'd0);
    check("unfrz2_ret_v",    {31'd0, bus.returning_v_o}, 32'd1);
    check("unfrz2_ret_data", bus.returning_data_o, 32'd0);
    check("unfrz2_freeze",   {28'd0, freeze_o}, 32'hB);
    check("unfrz2_core_v",   {28'd0, core_v_o}, 32'h4);
    check("unfrz2_core_rdy", {28'd0, core_ready_o}, 32'h4);
    tick();
    check("idle_ret_v", {31'd0, bus.returning_v_o}, 32'd0);

    // Status loads
    load_expect("ld_core2", 32'd2, 32'd0);
    load_expect("ld_core0", 32'd0, 32'd1);
    load_expect("ld_bcast", 32'd4, 32'hB);

    // Unmapped offsets
    load_expect("ld_unmap9", 32'd9, 32'd0);
    load_expect("ld_unmap5", 32'd5, 32'd0);
    req(1'b1, 32'd9, 32'd1);
    check("st_unmap9_ret", bus.returning_data_o, 32'd0);
    check("st_unmap9_a", {28'd0, freeze_o}, 32'hB);
    req(1'b1, 32'd9, 32'd0);
    check("st_unmap9_b", {28'd0, freeze_o}, 32'hB);

    // Freeze core 1 with credits outstanding
    req(1'b1, 32'd1, 32'd0);
    check("unfrz1_freeze", {28'd0, freeze_o}, 32'h9);
    out_credits_i[1] = 8'd197;
    req(1'b1, 32'd1, 32'd1);
`ifdef BRG_HCC_FREEZE_DRAIN_EN
    check("drain_freeze", {28'd0, freeze_o}, 32'h9);
    check("drain_core_v", {31'd0, core_v_o[1]}, 32'd0);
    for (int c = 198; c <= 200; c++) begin
      out_credits_i[1] = 8'(c);
      load_expect("drain_status", 32'd1, 32'd2);
      check("drain_core_v_loop", {31'd0, core_v_o[1]}, 32'd0);
      check("drain_frz_bit", {31'd0, freeze_o[1]}, (c == 200) ? 32'd1 : 32'd0);
    end
`else
    check("frz1_freeze", {28'd0, freeze_o}, 32'hB);
    check("frz1_core_v", {31'd0, core_v_o[1]}, 32'd0);
    out_credits_i[1] = 8'd200;
`endif
    load_expect("frz1_status", 32'd1, 32'd1);

    // Cancel a drain, then reset mid-drain
    out_credits_i[1] = 8'd150;
    req(1'b1, 32'd1, 32'd0);
    check("cancel_pre", {28'd0, freeze_o}, 32'h9);
    req(1'b1, 32'd1, 32'd1);
`ifdef BRG_HCC_FREEZE_DRAIN_EN
    load_expect("cancel_drain_st", 32'd1, 32'd2);
`else
    load_expect("cancel_drain_st", 32'd1, 32'd1);
`endif
    req(1'b1, 32'd1, 32'd0);
    check("cancel_run_v", {31'd0, core_v_o[1]}, 32'd1);
    load_expect("cancel_run_st", 32'd1, 32'd0);
    req(1'b1, 32'd1, 32'd1);
    reset_n_i = 1'b0;
    #1;
    check("midrst_freeze", {28'd0, freeze_o}, 32'hF);
    check("midrst_core_v", {28'd0, core_v_o}, 32'h0);
    tick();
    reset_n_i = 1'b1;
    out_credits_i[1] = 8'd200;
    tick();
    check("midrst_after", {28'd0, freeze_o}, 32'hF);

    // Broadcast unfreeze then freeze
    req(1'b1, 32'd4, 32'd0);
    check("bc_unfrz_freeze", {28'd0, freeze_o}, 32'h0);
    check("bc_unfrz_core_v", {28'd0, core_v_o}, 32'hF);
    check("bc_unfrz_rdy",    {28'd0, core_ready_o}, 32'h6);
    load_expect("bc_ld_run", 32'd4, 32'h0);
    req(1'b1, 32'd4, 32'd1);
    check("bc_frz_core_v", {28'd0, core_v_o}, 32'h0);
`ifdef BRG_HCC_FREEZE_DRAIN_EN
    check("bc_frz_draining", {28'd0, freeze_o}, 32'h0);
    tick();
`endif
    check("bc_frz_freeze", {28'd0, freeze_o}, 32'hF);
    load_expect("bc_ld_frozen", 32'd4, 32'hF);
    load_expect("bc_ld_core3", 32'd3, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_brg_hcc_freeze_ctrl
`default_nettype wire
